// File: rtl/fifo_read_stream.sv
// fifo_read_stream: turns a FIFO read port (empty/ren/rdata with one cycle
// of read latency) into a valid/ready stream through a 3-entry skid buffer.
// Optional feature: define FIFO_READ_STREAM_CNT_EN to add the 16-bit
// xfer_cnt output that counts stream handshakes.
module fifo_read_stream #(
    parameter int DW = 8
) (
    input  logic          rclk,
    input  logic          rrst,
    input  logic          flush,
    input  logic          empty,
    output logic          ren,
    input  logic [DW-1:0] rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [1:0]    occ
`ifdef FIFO_READ_STREAM_CNT_EN
    ,
    output logic [15:0]   xfer_cnt
`endif
);

    logic [DW-1:0] mem_q [3];
    logic [1:0]    rdPtr_q, rdPtr_d;
    logic [1:0]    wrPtr_q, wrPtr_d;
    logic [1:0]    occ_q, occ_d;
    logic          inflight_q, inflight_d;
    logic [2:0]    reserved;
    logic          capture;
    logic          pop;

    // Pointers walk 0,1,2,0 so the three slots are reused without a gap.
    function automatic logic [1:0] nextPtr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Slots already promised: buffered words plus the word coming back from the FIFO.
    always_comb begin
        reserved = {1'b0, occ_q} + {2'b0, inflight_q};
        ren      = !empty && !flush && !rrst && (reserved < 3'd3);
        capture  = inflight_q && !flush;
        pop      = m_valid && m_ready && !flush;
    end

    // Next-state for pointers, occupancy and the in-flight flag; flush wipes everything.
    always_comb begin
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        occ_d      = occ_q;
        inflight_d = inflight_q;
        if (flush) begin
            rdPtr_d    = 2'd0;
            wrPtr_d    = 2'd0;
            occ_d      = 2'd0;
            inflight_d = 1'b0;
        end else begin
            inflight_d = ren;
            if (capture) begin
                wrPtr_d = nextPtr(wrPtr_q);
            end
            if (pop) begin
                rdPtr_d = nextPtr(rdPtr_q);
            end
            case ({capture, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Control state register; reset drops any word still on its way from the FIFO.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rdPtr_q    <= 2'd0;
            wrPtr_q    <= 2'd0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
        end
    end

    // Buffer storage: the returning FIFO word lands at the tail one edge after its read.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
        end else if (capture) begin
            mem_q[wrPtr_q] <= rdata;
        end
    end

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = mem_q[rdPtr_q];
    assign occ     = occ_q;

`ifdef FIFO_READ_STREAM_CNT_EN
    logic [15:0] xferCnt_q;

    // Handshake counter, wraps naturally at 16 bits and is zeroed by flush.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            xferCnt_q <= 16'd0;
        end else if (flush) begin
            xferCnt_q <= 16'd0;
        end else if (m_valid && m_ready) begin
            xferCnt_q <= xferCnt_q + 16'd1;
        end
    end

    assign xfer_cnt = xferCnt_q;
`endif

endmodule

// File: doc/fifo_read_stream.md
FIFO_READ_STREAM -- requirements
Module: fifo_read_stream

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data width of FIFO read data and stream data.
REQ-002 SHALL have port rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port rrst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous clear of buffered and in-flight data.
REQ-005 SHALL have port empty  input  1  FIFO empty flag, synchronous to rclk.
REQ-006 SHALL have port ren  output  1  FIFO read enable.
REQ-007 SHALL have port rdata  input  DW  FIFO read data, valid in the cycle after an accepted ren.
REQ-008 SHALL have port m_valid  output  1  stream data valid.
REQ-009 SHALL have port m_ready  input  1  downstream ready.
REQ-010 SHALL have port m_data  output  DW  stream data (head of buffer).
REQ-011 SHALL have port occ  output  2  current buffer occupancy, 0..3.

Function
REQ-012 SHALL treat a FIFO read as accepted on a rising edge where ren=1 and empty=0.
REQ-013 SHALL hold an internal 3-entry in-order buffer plus a 1-bit in-flight flag set on each accepted read.
REQ-014 SHALL drive ren combinationally = !empty && !flush && !rrst && (occ + inflight) < 3; ren never asserted while empty=1.
REQ-015 SHALL capture rdata into the buffer tail on the edge after an accepted read and clear inflight unless a new read is accepted on that same edge.
REQ-016 SHALL drive m_valid = (occ != 0) and m_data = buffer head, registered and independent of m_ready.
REQ-017 SHALL pop the head on an edge where m_valid=1 and m_ready=1; m_data/m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-018 SHALL handle simultaneous capture and pop on the same edge with occ unchanged and order preserved.
REQ-019 SHALL give 2-cycle latency: read accepted at edge E0 -> m_valid=1 after edge E1 when buffer was empty.
REQ-020 SHALL sustain one transfer per cycle when empty=0 and m_ready=1 continuously.
REQ-021 SHALL never overflow: occ + inflight <= 3 at all times; occ never exceeds 3.
REQ-022 SHALL implement buffer pointers modulo 3, wrapping 2 -> 0 without bubble.
REQ-023 SHALL on flush=1 at an edge set occ=0, clear inflight, discard the in-flight word, and keep ren=0 during that cycle.
REQ-024 SHALL present m_valid=0 in the cycle after a flush edge regardless of m_ready.

Reset
REQ-025 SHALL on rrst=1 asynchronously set occ=0, inflight=0, pointers=0, m_valid=0, m_data=0.
REQ-026 SHALL hold ren=0 while rrst=1; a word in flight when reset asserts SHALL be discarded.
REQ-027 SHALL resume normal operation on the first rising edge after rrst deasserts.

Configuration
REQ-028 SHALL support macro FIFO_READ_STREAM_CNT_EN.
REQ-029 With FIFO_READ_STREAM_CNT_EN defined, SHALL add output xfer_cnt (16 bits) counting m_valid&&m_ready handshakes, wrapping 65535 -> 0, cleared to 0 by rrst and by flush.
REQ-030 Without FIFO_READ_STREAM_CNT_EN, SHALL omit the xfer_cnt port and counter logic; all other behaviour identical.

Verification
REQ-031 SHALL verify: reset, empty=1 throughout -> ren=0, m_valid=0, occ=0, m_data=0.
REQ-032 SHALL verify: FIFO model preloaded A1,B2,C3,D4, m_ready=1 -> m_data sequence A1,B2,C3,D4 on consecutive cycles, first m_valid 2 cycles after first accepted read.
REQ-033 SHALL verify: FIFO holds 8 words, m_ready=0 -> exactly 3 reads accepted, occ=3, ren=0; then m_ready=1 -> all 8 words in order, no loss or duplicate.
REQ-034 SHALL verify: flush asserted 1 cycle after read of E5 accepted with occ=2 -> occ=0 next cycle, E5 never appears on m_data, next word F6 delivered.
REQ-035 SHALL verify: rrst pulsed mid-stream with occ=2 -> m_valid=0 immediately (asynchronous), stream resumes with next FIFO word after release.
REQ-036 SHALL verify (FIFO_READ_STREAM_CNT_EN defined): 65537 handshakes -> xfer_cnt=1; flush -> xfer_cnt=0.
